// File: rtl/conv3x3_multich.sv
// conv3x3_multich: 3x3 multi-channel convolution over a rotating four-bank line buffer,
// producing one output row per start request with loadable weights, ReLU and saturation.
module conv3x3_multich #(
    parameter int IN_BD = 8,
    parameter int W_BD = 8,
    parameter int OUT_BD = 18,
    parameter int IN_CH = 3,
    parameter int OUT_CH = 3,
    parameter int IMG_W = 1920,
    parameter int AW = 11,
    localparam int NW = OUT_CH*IN_CH*9 + OUT_CH,
    localparam int WAW = $clog2(NW)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     wt_we,
    input  logic [WAW-1:0]           wt_addr,
    input  logic signed [W_BD-1:0]   wt_data,
    input  logic [IN_CH*IN_BD-1:0]   d0,
    input  logic [IN_CH*IN_BD-1:0]   d1,
    input  logic [IN_CH*IN_BD-1:0]   d2,
    input  logic [IN_CH*IN_BD-1:0]   d3,
    output logic                     rden,
    output logic [AW-1:0]            rdaddr,
    output logic [OUT_CH*OUT_BD-1:0] q,
    output logic                     wren,
    output logic [AW-1:0]            wraddr,
    output logic                     busy,
    output logic                     row_done,
    output logic [1:0]               bank_sel
);
    localparam int ACW = IN_BD + W_BD + $clog2(9*IN_CH) + 1;
    localparam int SW = (ACW > OUT_BD ? ACW : OUT_BD) + 1;
    localparam logic signed [SW-1:0] OMAX = (SW'(1) << (OUT_BD-1)) - SW'(1);
    localparam logic signed [SW-1:0] OMIN = -OMAX - SW'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n, a1, a2;
    logic pending, pending_n, pend_relu, pend_relu_n, relu, relu_n;
    logic start_q, start_qq, start_edge, v1, v2;
    logic [1:0] bank_n;
    logic signed [W_BD-1:0] wt [NW];
    logic [IN_BD-1:0] win [3][3][IN_CH];
    logic [IN_CH*IN_BD-1:0] bank [4];
    logic [IN_CH*IN_BD-1:0] row_word [3];
    logic signed [ACW-1:0] acc [OUT_CH];
    logic signed [SW-1:0] ext;
    logic [OUT_CH*OUT_BD-1:0] post;

    assign bank = '{d0, d1, d2, d3};
    assign start_edge = start_q & ~start_qq;
    assign busy = state != IDLE;
    assign rden = state == READ;
    assign rdaddr = rden ? cnt : '0;
    assign row_done = state == DRAIN && cnt == AW'(3);

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        pending_n = pending;
        pend_relu_n = pend_relu;
        relu_n = relu;
        bank_n = bank_sel;
        case (state)
            IDLE: if (pending || start_edge) begin
                state_n = READ;
                cnt_n = '0;
                pending_n = 1'b0;
                relu_n = pending ? pend_relu : relu_en;
            end
            READ: begin
                cnt_n = cnt + 1'b1;
                if (cnt == AW'(IMG_W-1)) begin
                    state_n = DRAIN;
                    cnt_n = '0;
                end
            end
            DRAIN: begin
                cnt_n = cnt + 1'b1;
                if (row_done) begin
                    state_n = pending ? READ : IDLE;
                    cnt_n = '0;
                    bank_n = bank_sel + 1'b1;
                    pending_n = 1'b0;
                    relu_n = pending ? pend_relu : relu;
                end
            end
            default: state_n = IDLE;
        endcase
        // one-deep queue: a second request while one is pending is dropped
        if (busy && start_edge && !pending) begin
            pending_n = 1'b1;
            pend_relu_n = relu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            pending <= 1'b0;
            pend_relu <= 1'b0;
            relu <= 1'b0;
            bank_sel <= '0;
            start_q <= 1'b0;
            start_qq <= 1'b0;
            for (int i = 0; i < NW; i++) wt[i] <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            pending <= pending_n;
            pend_relu <= pend_relu_n;
            relu <= relu_n;
            bank_sel <= bank_n;
            start_q <= start;
            start_qq <= start_q;
            if (state == IDLE && !pending && wt_we && {1'b0, wt_addr} < (WAW+1)'(NW)) wt[wt_addr] <= wt_data;
        end
    end

    always_comb begin
        ext = '0;
        post = '0;
        for (int r = 0; r < 3; r++) row_word[r] = bank[bank_sel + 2'(r)];
        for (int o = 0; o < OUT_CH; o++) begin
            acc[o] = ACW'(wt[OUT_CH*IN_CH*9 + o]);
            for (int i = 0; i < IN_CH; i++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc[o] = acc[o] + ACW'($signed({1'b0, win[r][c][i]})) * ACW'(wt[o*IN_CH*9 + i*9 + r*3 + c]);
            ext = (relu && acc[o][ACW-1]) ? '0 : SW'(acc[o]);
            post[(OUT_CH-1-o)*OUT_BD +: OUT_BD] = ext > OMAX ? OMAX[OUT_BD-1:0] : ext < OMIN ? OMIN[OUT_BD-1:0] : ext[OUT_BD-1:0];
        end
    end

    // window column 2 is the newest; output x is complete once column x+2 is shifted in
    always_ff @(posedge clk) begin
        if (v1)
            for (int r = 0; r < 3; r++)
                for (int i = 0; i < IN_CH; i++) begin
                    win[r][0][i] <= win[r][1][i];
                    win[r][1][i] <= win[r][2][i];
                    win[r][2][i] <= row_word[r][(IN_CH-1-i)*IN_BD +: IN_BD];
                end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            a1 <= '0;
            a2 <= '0;
            wren <= 1'b0;
            wraddr <= '0;
            q <= '0;
        end else begin
            v1 <= rden;
            a1 <= rdaddr;
            v2 <= v1 && a1 >= AW'(2);
            a2 <= a1 - AW'(2);
            wren <= v2;
            wraddr <= v2 ? a2 : '0;
            if (v2) q <= post;
        end
    end
endmodule

// File: tb/tb_conv3x3_multich.sv
// tb_conv3x3_multich: randomized bench for conv3x3_multich against an integer convolution model.
module tb_conv3x3_multich;
    localparam int IN_BD = 8, W_BD = 8, OUT_BD = 18, IN_CH = 3, OUT_CH = 3, IMG_W = 16, AW = 4;
    localparam int NW = OUT_CH*IN_CH*9 + OUT_CH;
    localparam int WAW = $clog2(NW);
    localparam int NO = IMG_W - 2;
    localparam longint OMAX = (longint'(1) << (OUT_BD-1)) - 1;
    localparam longint OMIN = -OMAX - 1;

    logic clk = 0, reset = 0, start = 0, relu_en = 0, wt_we = 0;
    logic [WAW-1:0] wt_addr = '0;
    logic [W_BD-1:0] wt_data = '0;
    logic [IN_CH*IN_BD-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic rden, wren, busy, row_done;
    logic [AW-1:0] rdaddr, wraddr;
    logic [OUT_CH*OUT_BD-1:0] q;
    logic [1:0] bank_sel;

    int wm [NW];
    int pix [4][IMG_W][IN_CH];
    int bs_m, checks, errors, cyc, t0, tw;
    logic [AW-1:0] cap_a [$];
    logic [OUT_CH*OUT_BD-1:0] cap_q [$];

    always #5 clk = ~clk;

    conv3x3_multich #(.IN_BD(IN_BD), .W_BD(W_BD), .OUT_BD(OUT_BD), .IN_CH(IN_CH), .OUT_CH(OUT_CH),
                      .IMG_W(IMG_W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en), .wt_we(wt_we),
        .wt_addr(wt_addr), .wt_data(wt_data), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .rden(rden), .rdaddr(rdaddr), .q(q), .wren(wren), .wraddr(wraddr),
        .busy(busy), .row_done(row_done), .bank_sel(bank_sel));

    function automatic logic [IN_CH*IN_BD-1:0] pack(int b, int col);
        logic [IN_CH*IN_BD-1:0] w = '0;
        for (int i = 0; i < IN_CH; i++) w[(IN_CH-1-i)*IN_BD +: IN_BD] = IN_BD'(pix[b][col][i]);
        return w;
    endfunction

    function automatic logic [OUT_CH*OUT_BD-1:0] model_q(int x, int bs, bit relu);
        logic [OUT_CH*OUT_BD-1:0] r = '0;
        longint acc;
        for (int o = 0; o < OUT_CH; o++) begin
            acc = wm[NW-OUT_CH+o];
            for (int i = 0; i < IN_CH; i++)
                for (int k = 0; k < 9; k++)
                    acc += longint'(pix[(bs + k/3) % 4][x + k%3][i]) * wm[o*IN_CH*9 + i*9 + k];
            if (relu && acc < 0) acc = 0;
            if (acc > OMAX) acc = OMAX;
            if (acc < OMIN) acc = OMIN;
            r[(OUT_CH-1-o)*OUT_BD +: OUT_BD] = OUT_BD'(acc);
        end
        return r;
    endfunction

    always @(posedge clk) if (rden) begin
        d0 <= pack(0, int'(rdaddr));
        d1 <= pack(1, int'(rdaddr));
        d2 <= pack(2, int'(rdaddr));
        d3 <= pack(3, int'(rdaddr));
    end

    always @(negedge clk) begin
        cyc++;
        if (rden && rdaddr == '0) t0 = cyc;
        if (wren) begin
            cap_a.push_back(wraddr);
            cap_q.push_back(q);
            if (wraddr == '0) tw = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse_start();
        @(posedge clk) #1 start = 1;
        @(posedge clk) #1 start = 0;
    endtask

    task automatic load_weights();
        for (int a = 0; a < NW; a++) begin
            @(posedge clk) #1 wt_we = 1;
            wt_addr = WAW'(a);
            wt_data = W_BD'(wm[a]);
        end
        @(posedge clk) #1 wt_we = 0;
    endtask

    task automatic write_one(input int a, input int v);
        @(posedge clk) #1 wt_we = 1;
        wt_addr = WAW'(a);
        wt_data = W_BD'(v);
        @(posedge clk) #1 wt_we = 0;
    endtask

    task automatic rand_all();
        foreach (pix[b, c, i]) pix[b][c][i] = int'($urandom_range(0, 255));
        foreach (wm[a]) wm[a] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic apply_reset();
        @(posedge clk) #1 reset = 0;
        @(posedge clk) #1 reset = 1;
        foreach (wm[a]) wm[a] = 0;
        bs_m = 0;
        cap_a.delete();
        cap_q.delete();
    endtask

    task automatic check_row(input string nm, input bit relu, input bit nxt);
        int n = 0;
        bit seen = 0;
        logic [OUT_CH*OUT_BD-1:0] e;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = row_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s row_done: not seen within %0d cycles", nm, n);
            return;
        end
        checks++;
        if (busy !== 1'b1 || wren !== 1'b0 || wraddr !== '0) begin
            errors++;
            $display("FAIL %s done_cycle: busy=%b wren=%b wraddr=%0d, want 1 0 0", nm, busy, wren, wraddr);
        end
        checks++;
        if (cap_a.size() != NO) begin
            errors++;
            $display("FAIL %s wren_count: got %0d, want %0d", nm, cap_a.size(), NO);
        end
        for (int x = 0; x < cap_a.size() && x < NO; x++) begin
            e = model_q(x, bs_m, relu);
            checks++;
            if (cap_a[x] !== AW'(x) || cap_q[x] !== e) begin
                errors++;
                $display("FAIL %s out[%0d]: wraddr=%0d q=%h, want wraddr=%0d q=%h", nm, x, cap_a[x], cap_q[x], x, e);
            end
        end
        checks++;
        if (tw - t0 != 5) begin
            errors++;
            $display("FAIL %s latency: got %0d, want 5", nm, tw - t0);
        end
        @(negedge clk);
        bs_m = (bs_m + 1) % 4;
        checks++;
        if (row_done !== 1'b0 || bank_sel !== 2'(bs_m) || busy !== nxt || rden !== nxt) begin
            errors++;
            $display("FAIL %s after_done: row_done=%b bank_sel=%0d busy=%b rden=%b, want 0 %0d %b %b",
                     nm, row_done, bank_sel, busy, rden, bs_m, nxt, nxt);
        end
        cap_a.delete();
        cap_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rden, rdaddr, wren, wraddr, q, busy, row_done, bank_sel} !== '0) begin
            errors++;
            $display("FAIL reset_values: rden=%b rdaddr=%0d wren=%b wraddr=%0d q=%h busy=%b row_done=%b bank_sel=%0d, want all 0",
                     rden, rdaddr, wren, wraddr, q, busy, row_done, bank_sel);
        end
        @(posedge clk) #1 reset = 1;
        bs_m = 0;
        foreach (wm[a]) wm[a] = 0;
    endtask

    task automatic test_unity();
        logic r0, r1, r2;
        foreach (pix[b, c, i]) pix[b][c][i] = 1;
        foreach (wm[a]) wm[a] = (a < NW - OUT_CH) ? 1 : 0;
        relu_en = 0;
        load_weights();
        @(posedge clk) #1 start = 1;
        @(negedge clk) r0 = rden;
        @(posedge clk) #1 start = 0;
        @(negedge clk) r1 = rden;
        @(negedge clk) r2 = rden;
        checks++;
        if ({r0, r1, r2} !== 3'b001 || rdaddr !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_timing: rden seq=%b%b%b rdaddr=%0d busy=%b, want 001 0 1", r0, r1, r2, rdaddr, busy);
        end
        check_row("unity", 0, 0);
    endtask

    task automatic test_center();
        foreach (pix[b, c, i]) pix[b][c][i] = (i == 0) ? c : 0;
        foreach (wm[a]) wm[a] = 0;
        wm[4] = 1;
        relu_en = 0;
        load_weights();
        pulse_start();
        check_row("center", 0, 0);
    endtask

    task automatic test_relu_sat();
        foreach (pix[b, c, i]) pix[b][c][i] = 255;
        foreach (wm[a]) wm[a] = (a < NW - OUT_CH) ? -1 : 0;
        load_weights();
        relu_en = 1;
        pulse_start();
        check_row("relu_on", 1, 0);
        relu_en = 0;
        pulse_start();
        check_row("relu_off", 0, 0);
        foreach (wm[a]) wm[a] = (a < NW - OUT_CH) ? 127 : 0;
        load_weights();
        pulse_start();
        check_row("sat_pos", 0, 0);
        foreach (wm[a]) wm[a] = (a < NW - OUT_CH) ? -128 : -128;
        load_weights();
        pulse_start();
        check_row("sat_neg", 0, 0);
    endtask

    task automatic test_random();
        bit rl;
        for (int n = 0; n < 3; n++) begin
            rand_all();
            load_weights();
            rl = 1'($urandom_range(0, 1));
            relu_en = rl;
            pulse_start();
            check_row("random", rl, 0);
        end
    endtask

    task automatic test_back_to_back();
        int idle_busy = 0;
        apply_reset();
        rand_all();
        load_weights();
        relu_en = 0;
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        repeat (2) @(posedge clk);
        pulse_start();
        check_row("b2b_row0", 0, 1);
        pulse_start();
        check_row("b2b_row1", 0, 1);
        pulse_start();
        check_row("b2b_row2", 0, 1);
        check_row("b2b_row3", 0, 0);
        repeat (20) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        checks++;
        if (idle_busy != 0) begin
            errors++;
            $display("FAIL b2b_dropped: busy for %0d cycles after last row, want 0", idle_busy);
        end
    endtask

    task automatic test_wt_busy();
        int a, v;
        rand_all();
        load_weights();
        relu_en = 0;
        a = int'($urandom_range(0, NW - 1));
        v = ((wm[a] + 128 + 77) % 256) - 128;
        pulse_start();
        repeat (2) @(posedge clk);
        write_one(a, v);
        pulse_start();
        write_one(a, v);
        check_row("wt_busy_cur", 0, 1);
        repeat (3) @(posedge clk);
        write_one(a, v);
        check_row("wt_busy_next", 0, 0);
        write_one(a, v);
        wm[a] = v;
        pulse_start();
        check_row("wt_idle", 0, 0);
    endtask

    task automatic test_reset_midrow();
        int n = 0, idle_busy = 0;
        bit hit = 0;
        rand_all();
        load_weights();
        relu_en = 0;
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        while (!hit && n < 100) begin
            @(negedge clk);
            n++;
            hit = wren && wraddr == AW'(4);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrow_wait: output 4 not seen within %0d cycles", n);
        end
        reset = 0;
        @(negedge clk);
        checks++;
        if ({rden, wren, wraddr, q, busy, row_done, bank_sel} !== '0) begin
            errors++;
            $display("FAIL midrow_reset: rden=%b wren=%b wraddr=%0d q=%h busy=%b row_done=%b bank_sel=%0d, want all 0",
                     rden, wren, wraddr, q, busy, row_done, bank_sel);
        end
        reset = 1;
        foreach (wm[a]) wm[a] = 0;
        bs_m = 0;
        cap_a.delete();
        cap_q.delete();
        repeat (30) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        checks++;
        if (idle_busy != 0) begin
            errors++;
            $display("FAIL midrow_pending: busy for %0d cycles after reset, want 0", idle_busy);
        end
        pulse_start();
        check_row("post_reset_zero_w", 0, 0);
        rand_all();
        load_weights();
        pulse_start();
        check_row("post_reset_full", 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unity();
        test_center();
        test_relu_sat();
        test_random();
        test_back_to_back();
        test_wt_busy();
        test_reset_midrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_multich.md
# conv3x3_multich

Parametrised 3x3 convolution engine: successor to the fixed 3-in/3-out, unity-weight conv layer. Reads three rows of a four-bank rotating line buffer, computes OUT_CH output channels over IN_CH input channels with runtime-loadable signed weights and biases, optional ReLU and output saturation, and emits one output row per start request to the downstream row BRAM. Sits between the line-buffer writer and the max-pool / next-conv stage.

## Interface
- IN_BD, 8: unsigned pixel width per channel
- W_BD, 8: signed weight/bias width
- OUT_BD, 18: signed output width per channel
- IN_CH, 3: input channels packed per bank word
- OUT_CH, 3: output channels
- IMG_W, 1920: input row width in pixels (>=4)
- AW, 11: address width (2^AW >= IMG_W)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  row request; rising edge detected internally
- relu_en  in  1  ReLU mode, sampled on accepted start
- wt_we  in  1  weight/bias write strobe
- wt_addr  in  clog2(OUT_CH*IN_CH*9+OUT_CH)  index: o*IN_CH*9+i*9+k (k=row*3+col), biases at OUT_CH*IN_CH*9+o
- wt_data  in  W_BD  signed weight/bias
- d0..d3  in  IN_CH*IN_BD each  bank read data, channel 0 in MSBs
- rden  out  1  bank read enable
- rdaddr  out  AW  bank read address
- q  out  OUT_CH*OUT_BD  result, channel 0 in MSBs
- wren  out  1  q valid / output write enable
- wraddr  out  AW  output address 0..IMG_W-3
- busy  out  1  row in progress
- row_done  out  1  one-cycle pulse after last output
- bank_sel  out  2  top-row bank index

## Operation
- States: IDLE, READ, DRAIN. Reset -> IDLE.
- IDLE: accepted start (0->1 edge) -> READ; latch relu_en; rdaddr=0, rden=1.
- READ: rdaddr increments 0..IMG_W-1; after IMG_W-1 -> DRAIN, rden=0.
- DRAIN: 3 cycles flushing pipeline, then row_done pulse, bank_sel+=1 (mod 4), -> IDLE (or READ if pending).
- Start edge while busy sets a one-deep pending flag; further edges while pending are dropped. Pending row starts the cycle after row_done, no idle gap.
- Row mapping: top=d[bank_sel], mid=d[bank_sel+1], bottom=d[bank_sel+2] (indices mod 4).
- Window: 3x3xIN_CH shift registers; new column shifted in every valid data cycle.
- Per output o: acc = sum over i,k of pixel(unsigned, zero-extended) * w(signed) + bias[o], full precision (IN_BD+W_BD+clog2(9*IN_CH)+1 bits, no intermediate overflow).
- Post: if relu_en and acc<0 -> 0; then saturate to [-2^(OUT_BD-1), 2^(OUT_BD-1)-1].
- Weights/biases: register file, reset to 0; wt_we honoured only in IDLE with no pending; ignored otherwise. Out-of-range wt_addr ignored.

## Timing
- Reset values: rden=0, rdaddr=0, wren=0, wraddr=0, q=0, busy=0, row_done=0, bank_sel=0, pending=0, all weights/biases 0.
- Start edge detect: start registered once; READ begins the cycle after the registered edge is seen (2 cycles after start rises).
- Bank read latency 1: data for rdaddr=a valid on d* next cycle.
- Pipeline: read cycle c (addr a) -> d valid c+1 -> window loaded end c+1 -> MAC registered end c+2 -> q/wren in c+3.
- Output x uses columns x..x+2; wren high for exactly IMG_W-2 consecutive cycles, first at 5 cycles after rdaddr=0 cycle; wraddr=x while wren.
- wraddr returns to 0 the cycle after last wren.
- busy high from first READ cycle through row_done cycle inclusive.
- row_done coincident with bank_sel increment visible next cycle.
- reset low mid-row: all state to reset values next edge, pending and partial row discarded.

## Test plan
- Weights all 1, biases 0, OUT_CH=3, all pixels 1: q each channel = 27 for wraddr 0..IMG_W-3, wren count = IMG_W-2, row_done once.
- Pixel value = column index on channel 0 only, center weight k=4 of (o=0,i=0) = 1: q ch0 at wraddr x = x+1, others 0.
- Weights -1, bias 0, pixels 255, relu_en=1: q=0; relu_en=0: q=-255*27 (in range for OUT_BD=18); W_BD=8 weights 127, pixels 255, OUT_BD=14: q saturates to 8191.
- Four back-to-back rows with start edge during busy: pending honoured, bank_sel 0->1->2->3->0, row mapping follows bank_sel, third start edge while pending dropped.
- wt_we during busy with new value: no effect on current or next row; same write in IDLE takes effect next row.
- reset low at output x=100: next cycle wren=0, busy=0, bank_sel=0, weights 0; new start runs a clean full row.
